// File: rtl/online_adder_rr_scheduler.sv
// Round-robin arbiter that time-shares one digit-serial online adder among NUM_REQ requesters,
// with an in-order ownership tag FIFO that steers result digits back to the frame owner.
module online_adder_rr_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MIN_GAP   = 2,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [2*NUM_REQ-1:0] i_wdata_x,
  input  logic [2*NUM_REQ-1:0] i_wdata_y,
  input  logic [NUM_REQ-1:0]   i_wvalid,
  input  logic [NUM_REQ-1:0]   i_wlast,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_add_wen,
  output logic [1:0]           o_add_wdata_x,
  output logic [1:0]           o_add_wdata_y,
  output logic                 o_add_wvalid,
  output logic                 o_add_wlast,
  input  logic [1:0]           i_add_rdata,
  input  logic                 i_add_rvalid,
  input  logic                 i_add_rlast,
  output logic [1:0]           o_rdata,
  output logic [NUM_REQ-1:0]   o_rvalid,
  output logic [NUM_REQ-1:0]   o_rlast,
  output logic                 o_busy,
  output logic [1:0]           o_err
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W  = TAG_AW + 1;
  localparam int unsigned GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_started;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_add_wen;
  logic               r_add_wvalid;
  logic               r_add_wlast;
  logic [1:0]         r_add_wdata_x;
  logic [1:0]         r_add_wdata_y;
  logic               r_err_wgap;
  logic               r_err_empty;

  logic [IDX_W-1:0]   r_tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0]  r_wr_ptr;
  logic [TAG_AW-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [1:0]         r_rdata;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [NUM_REQ-1:0] r_rlast;

  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_cand;
  logic [1:0]         w_sel_x;
  logic [1:0]         w_sel_y;
  logic               w_accept;
  logic               w_sel_wlast;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_res_hit;
  logic [NUM_REQ-1:0] w_head_oh;

  // First requesting index at or after the rr pointer; scanning high-to-low lets the nearest win.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      w_cand = IDX_W'((32'(r_rr_ptr) + 32'(i)) % NUM_REQ);
      if (i_req[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (r_owner == IDX_W'(k)) begin
        w_sel_x = i_wdata_x[2*k +: 2];
        w_sel_y = i_wdata_y[2*k +: 2];
      end
    end
  end

  assign w_accept    = |(r_grant & i_wvalid);
  assign w_sel_wlast = |(r_grant & i_wlast);
  assign w_push      = w_accept & ~r_started;
  assign w_full      = (r_count == CNT_W'(TAG_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_res_hit   = i_add_rvalid & ~w_empty;
  assign w_pop       = w_res_hit & i_add_rlast;
  assign w_head_oh   = NUM_REQ'(1) << r_tag_mem[r_rd_ptr];

  // Arbitration FSM and registered forwarding of the owner's digit stream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_started     <= 1'b0;
      r_gap_cnt     <= '0;
      r_add_wen     <= 1'b0;
      r_add_wvalid  <= 1'b0;
      r_add_wlast   <= 1'b0;
      r_add_wdata_x <= '0;
      r_add_wdata_y <= '0;
      r_err_wgap    <= 1'b0;
    end else begin
      r_add_wen     <= 1'b0;
      r_add_wvalid  <= 1'b0;
      r_add_wlast   <= 1'b0;
      r_add_wdata_x <= '0;
      r_add_wdata_y <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld && !w_full) begin
            r_grant   <= NUM_REQ'(1) << w_pick_idx;
            r_owner   <= w_pick_idx;
            r_started <= 1'b0;
            r_state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            r_add_wen     <= 1'b1;
            r_add_wvalid  <= 1'b1;
            r_add_wlast   <= w_sel_wlast;
            r_add_wdata_x <= w_sel_x;
            r_add_wdata_y <= w_sel_y;
            r_started     <= 1'b1;
            if (w_sel_wlast) begin
              r_grant   <= '0;
              r_rr_ptr  <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
              r_gap_cnt <= GAP_W'(MIN_GAP - 1);
              r_state   <= ST_GAP;
            end
          end else if (r_started) begin
            r_err_wgap <= 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ownership tag FIFO; count alone decides full/empty so push+pop in one cycle is neutral.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int d = 0; d < int'(TAG_DEPTH); d++) begin
        r_tag_mem[d] <= '0;
      end
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= r_owner;
        r_wr_ptr            <= r_wr_ptr + TAG_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + TAG_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result steering to the head-of-FIFO owner; digits arriving with no owner are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata     <= '0;
      r_rvalid    <= '0;
      r_rlast     <= '0;
      r_err_empty <= 1'b0;
    end else begin
      r_rdata  <= '0;
      r_rvalid <= '0;
      r_rlast  <= '0;
      if (w_res_hit) begin
        r_rdata  <= i_add_rdata;
        r_rvalid <= w_head_oh;
        r_rlast  <= i_add_rlast ? w_head_oh : '0;
      end else if (i_add_rvalid) begin
        r_err_empty <= 1'b1;
      end
    end
  end

  assign o_grant       = r_grant;
  assign o_add_wen     = r_add_wen;
  assign o_add_wdata_x = r_add_wdata_x;
  assign o_add_wdata_y = r_add_wdata_y;
  assign o_add_wvalid  = r_add_wvalid;
  assign o_add_wlast   = r_add_wlast;
  assign o_rdata       = r_rdata;
  assign o_rvalid      = r_rvalid;
  assign o_rlast       = r_rlast;
  assign o_busy        = (r_state != ST_IDLE) || !w_empty;
  assign o_err         = {r_err_empty, r_err_wgap};

endmodule
